// File: rtl/key_inversion.sv
// Inverse AES-128 key schedule: loads the round-10 key and emits round keys 10 down to 0,
// one per accepted valid/ready handshake, stepping the schedule back one round per cycle.
module key_inversion #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         startTransition,
  input  logic [127:0] lastRoundKey,
  input  logic         roundKeyReady,
  output logic         roundKeyValid,
  output logic [127:0] roundKeyOutput,
  output logic [3:0]   roundIndex,
  output logic         busy,
  output logic         done
);

  localparam int unsigned KEY_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input logic [IDX_W-1:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  state_t             state_q, state_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WORD_W-1:0]  w0, w1, w2, w3;
  logic [WORD_W-1:0]  p0, p1, p2, p3;
  logic [WORD_W-1:0]  g_word;
  logic [KEY_W-1:0]   key_prev;

  // One backward round: recover key (r-1) from key r using Rcon(r)
  always_comb begin
    w0 = key_q[127:96];
    w1 = key_q[95:64];
    w2 = key_q[63:32];
    w3 = key_q[31:0];
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    g_word = sub_word({p3[23:0], p3[31:24]}) ^ {rcon(idx_q), 24'h000000};
    p0 = w0 ^ g_word;
    key_prev = {p0, p1, p2, p3};
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (startTransition) begin
          key_d   = lastRoundKey;
          idx_d   = IDX_W'(NUM_ROUNDS);
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (valid_q && roundKeyReady) begin
          if (idx_q != '0) begin
            key_d = key_prev;
            idx_d = idx_q - IDX_W'(1);
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign roundKeyOutput = key_q;
  assign roundIndex     = idx_q;
  assign roundKeyValid  = valid_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_key_inversion.sv
// Testbench for key_inversion: forward-expansion reference model feeding a scoreboard queue,
// with a negedge monitor checking handshaken keys, hold-under-backpressure and the done pulse.
module tb_key_inversion;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         startTransition;
  logic [127:0] lastRoundKey;
  logic         roundKeyReady;
  logic         roundKeyValid;
  logic [127:0] roundKeyOutput;
  logic [3:0]   roundIndex;
  logic         busy;
  logic         done;

  key_inversion #(.NUM_ROUNDS(10)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .startTransition(startTransition),
    .lastRoundKey   (lastRoundKey),
    .roundKeyReady  (roundKeyReady),
    .roundKeyValid  (roundKeyValid),
    .roundKeyOutput (roundKeyOutput),
    .roundIndex     (roundIndex),
    .busy           (busy),
    .done           (done)
  );

  always #5 clock = ~clock;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  bit         rand_ready = 1'b0;
  logic [7:0] sbox_m [256];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out, got no completion, expected one", name);
  endtask

  // Reference S-box built from GF(2^8) inverse plus the affine map
  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Standard forward key expansion; returns round key r of cipher key k0
  function automatic logic [127:0] fwd_key(input logic [127:0] k0, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic push_seq(input logic [127:0] k0);
    exp_t e;
    for (int r = 10; r >= 0; r--) begin
      e.idx = 4'(r);
      e.key = fwd_key(k0, r);
      sb.push_back(e);
    end
  endtask

  task automatic push_fips();
    exp_t e;
    logic [127:0] k0;
    k0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    for (int r = 10; r >= 0; r--) begin
      e.idx = 4'(r);
      case (r)
        10:      e.key = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        9:       e.key = 128'hac7766f319fadc2128d12941575c006e;
        1:       e.key = 128'ha0fafe1788542cb123a339392a6c7605;
        0:       e.key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        default: e.key = fwd_key(k0, r);
      endcase
      sb.push_back(e);
    end
  endtask

  task automatic start_seq(input logic [127:0] k10);
    @(posedge clock); #1;
    startTransition = 1'b1;
    lastRoundKey    = k10;
    @(posedge clock); #1;
    startTransition = 1'b0;
    lastRoundKey    = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (sb.size() == 0 && !busy && !done && !roundKeyValid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout(name);
  endtask

  // Ready driver: held high, or randomly toggled for backpressure
  initial begin
    roundKeyReady = 1'b1;
    forever begin
      @(posedge clock); #1;
      roundKeyReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks hold and done timing
  logic         prev_valid, prev_ready;
  logic [127:0] prev_key;
  logic [3:0]   prev_idx;
  bit           have_prev = 1'b0;
  bit           exp_done  = 1'b0;

  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      have_prev = 1'b0;
      exp_done  = 1'b0;
    end else begin
      check("done_pulse", 128'(done), 128'(exp_done));
      if (exp_done) check("valid_after_last", 128'(roundKeyValid), 128'(0));
      exp_done = 1'b0;
      if (have_prev && prev_valid && !prev_ready) begin
        check("hold_valid", 128'(roundKeyValid), 128'(1));
        check("hold_key", roundKeyOutput, prev_key);
        check("hold_idx", 128'(roundIndex), 128'(prev_idx));
      end
      if (roundKeyValid && roundKeyReady) begin
        if (sb.size() == 0) begin
          check("unexpected_key_idx", 128'(roundIndex), 128'hffff);
        end else begin
          e = sb.pop_front();
          check("round_idx", 128'(roundIndex), 128'(e.idx));
          check("round_key", roundKeyOutput, e.key);
          if (e.idx == 4'd0) exp_done = 1'b1;
        end
      end
      prev_valid = roundKeyValid;
      prev_ready = roundKeyReady;
      prev_key   = roundKeyOutput;
      prev_idx   = roundIndex;
      have_prev  = 1'b1;
    end
  end

  initial begin
    logic [127:0] k0, ka, kb;
    bit ok;
    startTransition = 1'b0;
    lastRoundKey    = '0;
    reset_n         = 1'b1;
    init_sbox();
    #1 reset_n = 1'b0;
    #2;
    check("rst_valid", 128'(roundKeyValid), 128'(0));
    check("rst_key", roundKeyOutput, 128'(0));
    check("rst_idx", 128'(roundIndex), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;

    // FIPS-197 vector, ready held high
    push_fips();
    start_seq(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    wait_done("fips");

    // Same vector under random backpressure
    rand_ready = 1'b1;
    push_fips();
    start_seq(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    wait_done("fips_backpressure");
    rand_ready = 1'b0;

    // Start while busy with a different key must be ignored
    k0 = {$urandom(), $urandom(), $urandom(), $urandom()};
    push_seq(k0);
    start_seq(fwd_key(k0, 10));
    repeat (2) @(posedge clock);
    #1;
    startTransition = 1'b1;
    lastRoundKey    = {$urandom(), $urandom(), $urandom(), $urandom()};
    repeat (4) @(posedge clock);
    #1 startTransition = 1'b0;
    wait_done("start_while_busy");

    // Reset pulled at index 5
    k0 = {$urandom(), $urandom(), $urandom(), $urandom()};
    push_seq(k0);
    start_seq(fwd_key(k0, 10));
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (roundKeyValid && roundIndex == 4'd5) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("reach_index5");
    #2 reset_n = 1'b0;
    #1;
    check("midrst_valid", 128'(roundKeyValid), 128'(0));
    check("midrst_key", roundKeyOutput, 128'(0));
    check("midrst_idx", 128'(roundIndex), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_done", 128'(done), 128'(0));
    sb.delete();
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check("postrst_valid", 128'(roundKeyValid), 128'(0));
      check("postrst_busy", 128'(busy), 128'(0));
    end
    rand_ready = 1'b1;
    k0 = {$urandom(), $urandom(), $urandom(), $urandom()};
    push_seq(k0);
    start_seq(fwd_key(k0, 10));
    wait_done("after_reset");
    rand_ready = 1'b0;

    // Back-to-back: start held high through DONE
    ka = {$urandom(), $urandom(), $urandom(), $urandom()};
    kb = {$urandom(), $urandom(), $urandom(), $urandom()};
    push_seq(ka);
    @(posedge clock); #1;
    startTransition = 1'b1;
    lastRoundKey    = fwd_key(ka, 10);
    @(posedge clock); #1;
    lastRoundKey    = fwd_key(kb, 10);
    push_seq(kb);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("b2b_first_done");
    @(negedge clock);
    check("b2b_idle_valid", 128'(roundKeyValid), 128'(0));
    @(negedge clock);
    check("b2b_restart_valid", 128'(roundKeyValid), 128'(1));
    check("b2b_restart_idx", 128'(roundIndex), 128'(10));
    @(posedge clock); #1;
    startTransition = 1'b0;
    wait_done("b2b_second");

    // Round-trip against forward expansion for random keys
    for (int i = 0; i < 100; i++) begin
      rand_ready = i[0];
      k0 = {$urandom(), $urandom(), $urandom(), $urandom()};
      push_seq(k0);
      start_seq(fwd_key(k0, 10));
      wait_done("random_key");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
